cpu_dma_rx_pkt_writer: RTL and testbench

Ingress stage of the CPU DMA RX queue. It accepts packets from the user datapath and buffers them store-and-forward in an internal FIFO, exposing only fully committed packets to the DMA read side. It generates the per-packet event pulses and length counts that the CPU queue register block consumes, and it obeys that block's rx_queue_en. Drop decisions are made per packet, never per word.

---
 rtl/cpu_dma_rx_pkt_writer_pkg.sv | 24 ++
 rtl/cpu_dma_rx_pkt_writer_fifo_ram.sv | 22 ++
 rtl/cpu_dma_rx_pkt_writer.sv | 176 +++++++++++++++++
 tb/tb_cpu_dma_rx_pkt_writer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dma_rx_pkt_writer_pkg.sv
// Shared types and helpers for the CPU DMA RX packet writer.
// The optional drop counter is controlled by CPU_DMA_RX_DROP_CNT_EN (see top).
package cpu_dma_rx_pkt_writer_pkg;

   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_CTRL_WIDTH = DEF_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_STORE = 2'd1,
      ST_DROP  = 2'd2
   } rx_state_e;

   // EOP ctrl is one-hot: bit i set means 8-i valid bytes in the last word.
   function automatic logic [3:0] eop_bytes(input logic [7:0] ctrl);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (ctrl[i]) n = 4'(8 - i);
      end
      return n;
   endfunction

endpackage

// File: rtl/cpu_dma_rx_pkt_writer_fifo_ram.sv
// Simple dual-port RAM for the RX packet FIFO: synchronous write, asynchronous read.
module cpu_dma_rx_fifo_ram #(
   parameter int AW = 9,
   parameter int W  = 73
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_dma_rx_pkt_writer.sv
// Store-and-forward ingress of the CPU DMA RX queue; only committed packets are readable.
// Optional saturating drop counter output rx_drop_cnt when CPU_DMA_RX_DROP_CNT_EN is defined.
module cpu_dma_rx_pkt_writer
   import cpu_dma_rx_pkt_writer_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int CTRL_WIDTH    = DEF_CTRL_WIDTH,
   parameter int DEPTH         = 512,
   parameter int MAX_PKT_WORDS = 256
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  in_wr,
   output logic                  in_rdy,
   input  logic                  rx_queue_en,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_eop,
   output logic                  out_vld,
   input  logic                  out_rd,
   output logic                  rx_pkt_stored,
   output logic                  rx_pkt_removed,
   output logic                  rx_pkt_dropped,
   output logic                  rx_q_overrun,
   output logic                  rx_q_underrun,
   output logic [11:0]           rx_pkt_byte_cnt,
   output logic [9:0]            rx_pkt_word_cnt
`ifdef CPU_DMA_RX_DROP_CNT_EN
   ,
   output logic [15:0]           rx_drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int RW = DATA_WIDTH + CTRL_WIDTH + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
   localparam logic [PW-1:0] MAX_P   = PW'(MAX_PKT_WORDS);
   localparam logic [PW-1:0] ONE_P   = PW'(1);

   rx_state_e      state;
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  commit_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  pkt_words;
   logic [9:0]     data_cnt;
   logic           seen_data;

   logic [PW-1:0]  free;
   logic           is_ctrl;
   logic           is_eop;
   logic           admit;
   logic           wr_en;
   logic           pop;
   logic [RW-1:0]  rd_word;

   // Free space is judged against the pre-pop read pointer, so it errs on the safe side.
   assign free    = DEPTH_P - (wr_ptr - rd_ptr);
   assign is_ctrl = (in_ctrl != '0);
   assign is_eop  = is_ctrl && seen_data;
   assign admit   = rx_queue_en && (free >= MAX_P);
   assign wr_en   = reset_L && in_wr &&
                    (((state == ST_IDLE) && is_ctrl && admit) ||
                     ((state == ST_STORE) && (pkt_words != MAX_P)));
   assign out_vld = (rd_ptr != commit_ptr);
   assign pop     = out_rd && out_vld;

   cpu_dma_rx_fifo_ram #(.AW(AW), .W(RW)) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr[AW-1:0]),
      .wdata ({is_eop, in_ctrl, in_data}),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rd_word)
   );

   assign out_data = rd_word[DATA_WIDTH-1:0];
   assign out_ctrl = rd_word[DATA_WIDTH +: CTRL_WIDTH];
   assign out_eop  = rd_word[RW-1];

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state           <= ST_IDLE;
         wr_ptr          <= '0;
         commit_ptr      <= '0;
         rd_ptr          <= '0;
         pkt_words       <= '0;
         data_cnt        <= '0;
         seen_data       <= 1'b0;
         in_rdy          <= 1'b0;
         rx_pkt_stored   <= 1'b0;
         rx_pkt_removed  <= 1'b0;
         rx_pkt_dropped  <= 1'b0;
         rx_q_overrun    <= 1'b0;
         rx_q_underrun   <= 1'b0;
         rx_pkt_byte_cnt <= '0;
         rx_pkt_word_cnt <= '0;
      end else begin
         in_rdy         <= 1'b1;
         rx_pkt_stored  <= 1'b0;
         rx_pkt_dropped <= 1'b0;
         rx_q_overrun   <= 1'b0;
         rx_pkt_removed <= pop && out_eop;
         rx_q_underrun  <= out_rd && !out_vld;
         if (pop) rd_ptr <= rd_ptr + ONE_P;

         if (in_wr) begin
            case (state)
               ST_IDLE: begin
                  // A data word here means we joined mid-packet; drop until its EOP.
                  seen_data <= !is_ctrl;
                  data_cnt  <= '0;
                  if (is_ctrl && admit) begin
                     wr_ptr    <= wr_ptr + ONE_P;
                     pkt_words <= ONE_P;
                     state     <= ST_STORE;
                  end else begin
                     state     <= ST_DROP;
                  end
               end
               ST_STORE: begin
                  if (pkt_words == MAX_P) begin
                     wr_ptr       <= commit_ptr;
                     rx_q_overrun <= 1'b1;
                     if (is_eop) begin
                        rx_pkt_dropped <= 1'b1;
                        seen_data      <= 1'b0;
                        state          <= ST_IDLE;
                     end else begin
                        seen_data <= seen_data || !is_ctrl;
                        state     <= ST_DROP;
                     end
                  end else begin
                     wr_ptr    <= wr_ptr + ONE_P;
                     pkt_words <= pkt_words + ONE_P;
                     if (is_eop) begin
                        commit_ptr      <= wr_ptr + ONE_P;
                        rx_pkt_stored   <= 1'b1;
                        rx_pkt_word_cnt <= data_cnt + 10'd1;
                        rx_pkt_byte_cnt <= 12'({data_cnt, 3'b000}) + 12'(eop_bytes(8'(in_ctrl)));
                        seen_data       <= 1'b0;
                        state           <= ST_IDLE;
                     end else if (!is_ctrl) begin
                        data_cnt  <= data_cnt + 10'd1;
                        seen_data <= 1'b1;
                     end
                  end
               end
               ST_DROP: begin
                  if (is_eop) begin
                     rx_pkt_dropped <= 1'b1;
                     seen_data      <= 1'b0;
                     state          <= ST_IDLE;
                  end else if (!is_ctrl) begin
                     seen_data <= 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef CPU_DMA_RX_DROP_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         rx_drop_cnt <= '0;
      end else if (rx_pkt_dropped && (rx_drop_cnt != 16'hFFFF)) begin
         rx_drop_cnt <= rx_drop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cpu_dma_rx_pkt_writer.sv
// Self-checking bench for cpu_dma_rx_pkt_writer (default build, drop counter absent).
module tb_cpu_dma_rx_pkt_writer;

   localparam int DW = 64;
   localparam int CW = 8;
   localparam int RW = DW + CW + 1;

   logic          clk = 1'b0;
   logic          reset_L = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;
   logic          in_wr = 1'b0;
   logic          in_rdy;
   logic          rx_queue_en = 1'b0;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic          out_eop;
   logic          out_vld;
   logic          out_rd = 1'b0;
   logic          rx_pkt_stored;
   logic          rx_pkt_removed;
   logic          rx_pkt_dropped;
   logic          rx_q_overrun;
   logic          rx_q_underrun;
   logic [11:0]   rx_pkt_byte_cnt;
   logic [9:0]    rx_pkt_word_cnt;

   always #5 clk = ~clk;

   cpu_dma_rx_pkt_writer #(
      .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .DEPTH(512), .MAX_PKT_WORDS(256)
   ) dut (
      .clk(clk), .reset_L(reset_L), .in_data(in_data), .in_ctrl(in_ctrl),
      .in_wr(in_wr), .in_rdy(in_rdy), .rx_queue_en(rx_queue_en),
      .out_data(out_data), .out_ctrl(out_ctrl), .out_eop(out_eop),
      .out_vld(out_vld), .out_rd(out_rd), .rx_pkt_stored(rx_pkt_stored),
      .rx_pkt_removed(rx_pkt_removed), .rx_pkt_dropped(rx_pkt_dropped),
      .rx_q_overrun(rx_q_overrun), .rx_q_underrun(rx_q_underrun),
      .rx_pkt_byte_cnt(rx_pkt_byte_cnt), .rx_pkt_word_cnt(rx_pkt_word_cnt)
   );

   int n_checks = 0;
   int n_pass = 0;
   logic [RW-1:0] exp_q[$];
   int n_stored = 0, n_dropped = 0, n_removed = 0, n_overrun = 0, n_underrun = 0;
   int word_idx = 0;
   int ovr_at = 0;
   bit flip_req = 1'b0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (rx_pkt_stored)  n_stored++;
      if (rx_pkt_dropped) n_dropped++;
      if (rx_pkt_removed) n_removed++;
      if (rx_q_overrun)   n_overrun++;
      if (rx_q_underrun)  n_underrun++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // One word per cycle; an overrun pulse seen here belongs to the previously driven word.
   task automatic drive(input logic [7:0] c, input logic [63:0] d, input bit keep, input bit eop);
      @(negedge clk);
      if (rx_q_overrun) ovr_at = word_idx;
      word_idx++;
      in_wr = 1'b1;
      in_ctrl = c;
      in_data = d;
      if (keep) exp_q.push_back({eop, c, d});
      if (flip_req && word_idx == 2) rx_queue_en = !rx_queue_en;
   endtask

   task automatic idle();
      @(negedge clk);
      if (rx_q_overrun) ovr_at = word_idx;
      in_wr = 1'b0;
      in_ctrl = '0;
   endtask

   // ndata counts the zero-ctrl words plus the EOP word.
   task automatic send_pkt(input int nhdr, input int ndata, input int bitpos, input bit keep, input bit flip);
      logic [7:0] eop_c;
      eop_c = 8'(1 << bitpos);
      word_idx = 0;
      ovr_at = 0;
      flip_req = flip;
      for (int h = 0; h < nhdr; h++)
         drive((h == 0) ? 8'hFF : 8'($urandom_range(1, 255)), {$urandom, $urandom}, keep, 1'b0);
      for (int i = 0; i < ndata - 1; i++)
         drive(8'h00, {$urandom, $urandom}, keep, 1'b0);
      drive(eop_c, {$urandom, $urandom}, keep, 1'b1);
      idle();
      flip_req = 1'b0;
   endtask

   task automatic check_stored(input string tag, input int ndata, input int bitpos);
      check({tag, "_stored"}, rx_pkt_stored, 1);
      check({tag, "_word_cnt"}, rx_pkt_word_cnt, ndata);
      check({tag, "_byte_cnt"}, rx_pkt_byte_cnt, 8 * (ndata - 1) + (8 - bitpos));
   endtask

   task automatic drain(input int n, input int budget);
      int popped = 0;
      int cyc = 0;
      while (popped < n && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (out_vld) begin
            if (exp_q.size() == 0) check("sb_nonempty", 0, 1);
            else check("pop_word", {out_eop, out_ctrl, out_data}, exp_q.pop_front());
            out_rd = 1'b1;
            popped++;
         end else begin
            out_rd = 1'b0;
         end
      end
      @(negedge clk);
      out_rd = 1'b0;
      check("drain_count", popped, n);
   endtask

   task automatic settle();
      repeat (2) @(negedge clk);
      #1;
   endtask

   initial begin
      int s0, d0, r0, o0, u0;
      int nh[4], nd[4], bp[4];
      int total;
      logic [9:0] rd_save;

      // reset
      repeat (3) @(negedge clk);
      check("rst_in_rdy", in_rdy, 0);
      check("rst_out_vld", out_vld, 0);
      check("rst_pulses", {rx_pkt_stored, rx_pkt_removed, rx_pkt_dropped, rx_q_overrun, rx_q_underrun}, 0);
      check("rst_counts", {rx_pkt_byte_cnt, rx_pkt_word_cnt}, 0);
      reset_L = 1'b1;
      @(negedge clk);
      check("in_rdy_after_rst", in_rdy, 1);

      // basic store and drain
      rx_queue_en = 1'b1;
      s0 = n_stored; r0 = n_removed;
      send_pkt(1, 8, 2, 1'b1, 1'b0);
      check_stored("t1", 8, 2);
      check("t1_byte_62", rx_pkt_byte_cnt, 62);
      check("t1_out_vld", out_vld, 1);
      @(negedge clk);
      check("t1_stored_1cyc", rx_pkt_stored, 0);
      drain(9, 100);
      check("t1_out_vld_empty", out_vld, 0);
      settle();
      check("t1_n_stored", n_stored - s0, 1);
      check("t1_n_removed", n_removed - r0, 1);

      // disabled queue, enable raised mid-packet
      rx_queue_en = 1'b0;
      s0 = n_stored; d0 = n_dropped;
      send_pkt(1, 8, 2, 1'b0, 1'b1);
      check("t2_dropped", rx_pkt_dropped, 1);
      check("t2_out_vld", out_vld, 0);
      settle();
      check("t2_n_stored", n_stored - s0, 0);
      check("t2_n_dropped", n_dropped - d0, 1);

      // enabled at SOP, disabled mid-packet: still stored
      rx_queue_en = 1'b1;
      send_pkt(2, 5, 7, 1'b1, 1'b1);
      check_stored("t3", 5, 7);
      rx_queue_en = 1'b1;
      drain(7, 100);

      // free-space boundary: exactly MAX free accepted, less is dropped
      s0 = n_stored; d0 = n_dropped;
      send_pkt(1, 255, 0, 1'b1, 1'b0);
      check_stored("t4a", 255, 0);
      send_pkt(1, 2, 3, 1'b1, 1'b0);
      check_stored("t4b", 2, 3);
      send_pkt(1, 2, 3, 1'b0, 1'b0);
      check("t4c_dropped", rx_pkt_dropped, 1);
      check("t4c_not_stored", rx_pkt_stored, 0);
      drain(259, 600);
      settle();
      check("t4_n_stored", n_stored - s0, 2);
      check("t4_n_dropped", n_dropped - d0, 1);

      // oversize packet
      s0 = n_stored; d0 = n_dropped; o0 = n_overrun;
      send_pkt(1, 299, 0, 1'b0, 1'b0);
      check("t5_dropped", rx_pkt_dropped, 1);
      check("t5_ovr_word", ovr_at, 257);
      check("t5_rollback", dut.wr_ptr, dut.commit_ptr);
      check("t5_out_vld", out_vld, 0);
      settle();
      check("t5_n_overrun", n_overrun - o0, 1);
      check("t5_n_dropped", n_dropped - d0, 1);
      check("t5_n_stored", n_stored - s0, 0);

      // underrun
      u0 = n_underrun;
      rd_save = dut.rd_ptr;
      @(negedge clk);
      out_rd = 1'b1;
      @(negedge clk);
      out_rd = 1'b0;
      check("t6_underrun", rx_q_underrun, 1);
      check("t6_rd_ptr", dut.rd_ptr, rd_save);
      @(negedge clk);
      check("t6_underrun_1cyc", rx_q_underrun, 0);
      #1;
      check("t6_n_underrun", n_underrun - u0, 1);

      // random packets with concurrent reads (commit and pop may coincide)
      total = 0;
      for (int i = 0; i < 4; i++) begin
         nh[i] = $urandom_range(1, 3);
         nd[i] = $urandom_range(2, 20);
         bp[i] = $urandom_range(0, 7);
         total += nh[i] + nd[i];
      end
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               send_pkt(nh[i], nd[i], bp[i], 1'b1, 1'b0);
               check_stored("rnd", nd[i], bp[i]);
            end
         end
         drain(total, 2000);
      join

      // reset mid-packet, headerless tail must be dropped
      d0 = n_dropped;
      word_idx = 0;
      drive(8'hFF, {$urandom, $urandom}, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(8'h00, {$urandom, $urandom}, 1'b0, 1'b0);
      @(negedge clk);
      in_wr = 1'b0;
      reset_L = 1'b0;
      @(negedge clk);
      check("t7_ptrs_zero", {dut.wr_ptr, dut.commit_ptr, dut.rd_ptr}, 0);
      check("t7_in_rdy_rst", in_rdy, 0);
      reset_L = 1'b1;
      for (int i = 0; i < 4; i++) drive(8'h00, {$urandom, $urandom}, 1'b0, 1'b0);
      drive(8'h01, {$urandom, $urandom}, 1'b0, 1'b1);
      idle();
      check("t7_tail_dropped", rx_pkt_dropped, 1);
      check("t7_out_vld", out_vld, 0);
      send_pkt(1, 4, 4, 1'b1, 1'b0);
      check_stored("t7_next", 4, 4);
      drain(5, 100);
      settle();
      check("t7_n_dropped", n_dropped - d0, 1);
      check("sb_empty_end", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
